// File: rtl/airlock_pkg.sv
// rtl/airlock_pkg.sv - shared state encoding and fault codes for the airlock chamber sequencers
package airlock_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FILL   = ST_FILL,
    DRAIN  = ST_DRAIN,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE,
    FAULT  = ST_FAULT
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_DOOR    = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  function automatic logic is_busy(input state_t s);
    return (s == FILL) || (s == DRAIN) || (s == SETTLE);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - up counter with sync clear, enable and terminal-value match
module cycle_counter #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] TERMINAL = '0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic at_terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == TERMINAL);

endmodule

// File: rtl/chamber_pressure_sequencer.sv
// rtl/chamber_pressure_sequencer.sv - drives one chamber to pressurized/depressurized with
// settle confirmation, timeout, abort and door-interlock fault latching
module chamber_pressure_sequencer
  import airlock_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       clear,
  input  logic       InnerClosed,
  input  logic       OuterClosed,
  input  logic       Pressurized,
  output logic       FandP,
  output logic       Drain,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  state_t     state, nxt;
  logic       mode_q;
  logic [1:0] nxt_code;
  logic       door_ok, target;
  logic       to_en, to_clr, to_term;
  logic       st_en, st_clr, st_term;

  assign door_ok = InnerClosed && OuterClosed;
  // In IDLE the request's own mode decides whether the target is already met.
  assign target  = ((state == IDLE) ? mode : mode_q) ? Pressurized : !Pressurized;

  assign to_clr = (state == IDLE);
  assign st_clr = (state != SETTLE);

  cycle_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (CNT_W'(TIMEOUT_CYCLES - 1))
  ) u_timeout (
    .Clock       (Clock),
    .Reset       (Reset),
    .clear       (to_clr),
    .enable      (to_en),
    .at_terminal (to_term)
  );

  cycle_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (CNT_W'(SETTLE_CYCLES - 1))
  ) u_settle (
    .Clock       (Clock),
    .Reset       (Reset),
    .clear       (st_clr),
    .enable      (st_en),
    .at_terminal (st_term)
  );

  always_comb begin
    nxt      = state;
    nxt_code = (state == FAULT) ? fault_code : FC_NONE;
    to_en    = 1'b0;
    st_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!door_ok) begin
            nxt      = FAULT;
            nxt_code = FC_DOOR;
          end else if (target) begin
            nxt = SETTLE;
          end else begin
            nxt = mode ? FILL : DRAIN;
          end
        end
      end
      FILL, DRAIN: begin
        if (!door_ok) begin
          nxt      = FAULT;
          nxt_code = FC_DOOR;
        end else if (abort) begin
          nxt = IDLE;
        end else if (target) begin
          nxt = SETTLE;
        end else if (to_term) begin
          nxt      = FAULT;
          nxt_code = FC_TIMEOUT;
        end else begin
          to_en = 1'b1;
        end
      end
      SETTLE: begin
        if (!door_ok) begin
          nxt      = FAULT;
          nxt_code = FC_DOOR;
        end else if (abort) begin
          nxt = IDLE;
        end else if (!target) begin
          // Timeout budget is shared across re-entries, so the counter keeps its value.
          nxt = mode_q ? FILL : DRAIN;
        end else if (st_term) begin
          nxt = DONE;
        end else begin
          st_en = 1'b1;
        end
      end
      DONE: nxt = IDLE;
      FAULT: begin
        if (clear) begin
          nxt      = IDLE;
          nxt_code = FC_NONE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      FandP      <= 1'b0;
      Drain      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        mode_q <= mode;
      end
      FandP      <= (nxt == FILL);
      Drain      <= (nxt == DRAIN);
      busy       <= is_busy(nxt);
      done       <= (nxt == DONE);
      fault      <= (nxt == FAULT);
      fault_code <= nxt_code;
    end
  end

endmodule

// File: tb/tb_chamber_pressure_sequencer.sv
// tb/tb_chamber_pressure_sequencer.sv - scoreboard bench for chamber_pressure_sequencer
module tb_chamber_pressure_sequencer;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_FILL   = 7'b1010000;
  localparam logic [6:0] O_DRAIN  = 7'b0110000;
  localparam logic [6:0] O_SETTLE = 7'b0010000;
  localparam logic [6:0] O_DONE   = 7'b0001000;
  localparam logic [6:0] O_F_DOOR = 7'b0000101;
  localparam logic [6:0] O_F_TO   = 7'b0000110;

  logic       Clock = 1'b0;
  logic       Reset, start, mode, abort, clear;
  logic       InnerClosed, OuterClosed, Pressurized;
  logic       FandP, Drain, busy, done, fault;
  logic [1:0] fault_code;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] exp_q[$];

  always #5 Clock = ~Clock;

  chamber_pressure_sequencer #(
    .CNT_W          (16),
    .TIMEOUT_CYCLES (10),
    .SETTLE_CYCLES  (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .start       (start),
    .mode        (mode),
    .abort       (abort),
    .clear       (clear),
    .InnerClosed (InnerClosed),
    .OuterClosed (OuterClosed),
    .Pressurized (Pressurized),
    .FandP       (FandP),
    .Drain       (Drain),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  function automatic logic [6:0] outs();
    return {FandP, Drain, busy, done, fault, fault_code};
  endfunction

  task automatic drive(input logic rst, input logic st, input logic md, input logic ab,
                       input logic cl, input logic ic, input logic oc, input logic pr);
    Reset = rst; start = st; mode = md; abort = ab; clear = cl;
    InnerClosed = ic; OuterClosed = oc; Pressurized = pr;
  endtask

  task automatic test_reset;
    logic [6:0] got, exp;
    @(negedge Clock);
    for (int c = 0; c < 4; c++) exp_q.push_back(O_IDLE);
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, c < 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_fill_done;
    logic [6:0] got, exp;
    for (int c = 0; c < 12; c++)
      exp_q.push_back(c < 5 ? O_FILL : c < 9 ? O_SETTLE : c == 9 ? O_DONE : O_IDLE);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, c == 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c >= 5);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL fill_done c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_timeout;
    logic [6:0] got, exp;
    for (int c = 0; c < 15; c++)
      exp_q.push_back(c < 10 ? O_FILL : c < 13 ? O_F_TO : O_IDLE);
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, c == 0 || c == 11, 1'b1, c == 12, c == 13, 1'b1, 1'b1, 1'b0);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL timeout c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_door_fault;
    logic [6:0] got, exp;
    for (int c = 0; c < 8; c++)
      exp_q.push_back(c < 3 ? O_FILL : c < 6 ? O_F_DOOR : O_IDLE);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, c == 0 || c == 4 || c == 5 || c == 6, 1'b1, 1'b0, c == 6,
            1'b1, c != 3, 1'b0);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL door_fault c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_drain_rebound;
    logic [6:0] got, exp;
    for (int c = 0; c < 13; c++)
      exp_q.push_back(c < 3 ? O_DRAIN : c < 5 ? O_SETTLE : c < 7 ? O_DRAIN :
                      c < 11 ? O_SETTLE : c == 11 ? O_DONE : O_IDLE);
    for (int c = 0; c < 13; c++) begin
      // mode flips mid-sequence and must be ignored outside IDLE
      drive(1'b0, c == 0, c >= 2, 1'b0, 1'b0, 1'b1, 1'b1, c < 3 || c == 5 || c == 6);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL drain_rebound c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] got, exp;
    for (int c = 0; c < 7; c++)
      exp_q.push_back(c < 4 ? O_SETTLE : c == 4 ? O_DONE : O_IDLE);
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, c == 0 || c == 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_abort_reset;
    logic [6:0] got, exp;
    for (int c = 0; c < 4; c++) exp_q.push_back(c < 2 ? O_FILL : O_IDLE);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, c == 0, 1'b1, c == 2, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort c%0d got %b exp %b", c, got, exp);
      end
    end
    for (int c = 0; c < 7; c++) exp_q.push_back(c < 2 ? O_SETTLE : O_IDLE);
    for (int c = 0; c < 7; c++) begin
      drive(c == 2, c == 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge Clock);
      got = outs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_settle c%0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    test_reset();
    test_fill_done();
    test_timeout();
    test_door_fault();
    test_drain_rebound();
    test_back_to_back();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
